// File: rtl/mau_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mau_pkg
//  Description : Shared types and constants for the memory access unit.
//                DATA_W / ADDR_W  - data and address widths of the load/store
//                                   path and the data memory.
//                MAU_DEPTH        - default number of 32-bit words in the
//                                   data memory.
//                mau_state_e      - request FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package mau_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MAU_DEPTH = 65536;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } mau_state_e;

endpackage : mau_pkg
`default_nettype wire

// File: rtl/mau_if.sv
`default_nettype none
// ============================================================================
//  Module      : mau_if
//  Description : Bundle of the request/response handshake and the data
//                memory bus seen by the memory access unit.
//                slave  modport - the memory access unit itself.
//                master modport - the surrounding pipeline and data memory.
//                Request  : in_req_valid / out_req_ready, in_req_write,
//                           in_req_addr, in_req_wdata
//                Response : out_resp_valid / in_resp_ready, out_resp_rdata,
//                           out_resp_err
//                Memory   : out_mem_read, out_mem_write, out_mem_addr,
//                           out_mem_wdata, in_mem_rdata
//  Revision    : 1.0 - initial release
// ============================================================================
interface mau_if;
    import mau_pkg::*;

    logic              in_req_valid;
    logic              out_req_ready;
    logic              in_req_write;
    logic [ADDR_W-1:0] in_req_addr;
    logic [DATA_W-1:0] in_req_wdata;

    logic              out_resp_valid;
    logic              in_resp_ready;
    logic [DATA_W-1:0] out_resp_rdata;
    logic              out_resp_err;

    logic              out_mem_read;
    logic              out_mem_write;
    logic [ADDR_W-1:0] out_mem_addr;
    logic [DATA_W-1:0] out_mem_wdata;
    logic [DATA_W-1:0] in_mem_rdata;

    modport slave (
        input  in_req_valid, in_req_write, in_req_addr, in_req_wdata,
        input  in_resp_ready, in_mem_rdata,
        output out_req_ready, out_resp_valid, out_resp_rdata, out_resp_err,
        output out_mem_read, out_mem_write, out_mem_addr, out_mem_wdata
    );

    modport master (
        output in_req_valid, in_req_write, in_req_addr, in_req_wdata,
        output in_resp_ready, in_mem_rdata,
        input  out_req_ready, out_resp_valid, out_resp_rdata, out_resp_err,
        input  out_mem_read, out_mem_write, out_mem_addr, out_mem_wdata
    );

endinterface : mau_if
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Single-outstanding load/store initiator between the CPU
//                memory stage and a data memory with registered read data.
//                IDLE -> ISSUE (one-cycle strobe) -> [CAPTURE for loads] ->
//                RESP (held until in_resp_ready).
//  Ports       : clk    - rising-edge clock shared with the data memory
//                rst_n  - asynchronous active-low reset
//                bus    - mau_if.slave (request, response and memory bus)
//  Parameters  : DEPTH  - number of 32-bit words in the data memory
//  Options     : MAU_ADDR_CHECK_EN - when defined, requests with an address
//                >= DEPTH are answered with out_resp_err=1 without touching
//                memory. When undefined, out_resp_err stays 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int DEPTH = MAU_DEPTH
) (
    input  wire logic clk,
    input  wire logic rst_n,
    mau_if.slave      bus
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_ISSUE   = ISSUE;
    localparam logic [1:0] S_CAPTURE = CAPTURE;
    localparam logic [1:0] S_RESP    = RESP;

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       r_write;
    logic       w_accept;
    logic       w_fault;

    assign w_accept = (r_state == S_IDLE) && bus.in_req_valid;

`ifdef MAU_ADDR_CHECK_EN
    assign w_fault = (bus.in_req_addr >= ADDR_W'(DEPTH));
`else
    logic w_unused_cfg;
    assign w_fault      = 1'b0;
    assign w_unused_cfg = ^(ADDR_W'(DEPTH));
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.in_req_valid) w_next = w_fault ? S_RESP : S_ISSUE;
            S_ISSUE:   w_next = r_write ? S_RESP : S_CAPTURE;
            S_CAPTURE: w_next = S_RESP;
            S_RESP:    if (bus.in_resp_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Every output is a flop loaded from the next-state decode, so outputs
    // change only on clock edges (or asynchronously on reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_write            <= 1'b0;
            bus.out_req_ready  <= 1'b1;
            bus.out_resp_valid <= 1'b0;
            bus.out_resp_rdata <= '0;
            bus.out_resp_err   <= 1'b0;
            bus.out_mem_read   <= 1'b0;
            bus.out_mem_write  <= 1'b0;
            bus.out_mem_addr   <= '0;
            bus.out_mem_wdata  <= '0;
        end else begin
            r_state            <= w_next;
            bus.out_req_ready  <= (w_next == S_IDLE);
            bus.out_resp_valid <= (w_next == S_RESP);
            bus.out_mem_read   <= 1'b0;
            bus.out_mem_write  <= 1'b0;

            if (w_accept) begin
                r_write          <= bus.in_req_write;
                bus.out_resp_err <= w_fault;
                if (w_fault) begin
                    // Faulting requests never reach memory, so the memory
                    // address/data keep their previous values.
                    bus.out_resp_rdata <= '0;
                end else begin
                    bus.out_mem_addr  <= bus.in_req_addr;
                    bus.out_mem_wdata <= bus.in_req_wdata;
                    bus.out_mem_read  <= ~bus.in_req_write;
                    bus.out_mem_write <= bus.in_req_write;
                end
            end

            if ((r_state == S_ISSUE) && r_write) begin
                bus.out_resp_rdata <= '0;
            end

            // Memory registered its read data on the ISSUE closing edge.
            if (r_state == S_CAPTURE) begin
                bus.out_resp_rdata <= bus.in_mem_rdata;
            end
        end
    end

endmodule : mem_access_unit
`default_nettype wire
